// File: rtl/latch_share_pkg.sv
// Shared types and helpers for the latch-share arbiter.
//   state_e     : transaction FSM states
//   MaxNReq     : largest supported requester count
//   clog2_min1  : ceil(log2(value)) clamped to at least 1, for index and counter widths
package latch_share_pkg;

  localparam int unsigned MaxNReq = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StHold,
    StAck
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = $clog2(value);
    return (w == 0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/latch_share_arbiter_if.sv
// Client/latch bundle of the latch-share arbiter.
//   i_req, i_data : per-requester request and write data (slice r is [r*W +: W])
//   o_gnt, o_ack  : one-hot grant and single-cycle completion strobe
//   o_en, o_d     : enable and data into the shared latch
//   i_q           : readback of the shared latch
//   o_q           : captured readback, valid while o_ack is non-zero
//   o_busy, o_err : not-idle flag and sticky readback mismatch flag
// master: the arbiter side. slave: the clients/latch side.
interface latch_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 1
);
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ*W-1:0] i_data;
  logic [N_REQ-1:0]   o_gnt;
  logic [N_REQ-1:0]   o_ack;
  logic               o_en;
  logic [W-1:0]       o_d;
  logic [W-1:0]       i_q;
  logic [W-1:0]       o_q;
  logic               o_busy;
  logic               o_err;

  modport master (
    input  i_req, i_data, i_q,
    output o_gnt, o_ack, o_en, o_d, o_q, o_busy, o_err
  );

  modport slave (
    output i_req, i_data, i_q,
    input  o_gnt, o_ack, o_en, o_d, o_q, o_busy, o_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : index where the ascending, wrapping search starts
//   mask : requests to ignore (set bits are excluded)
//   gnt  : one-hot winner, all zero when nothing is eligible
//   idx  : binary index of the winner (0 when nothing is eligible)
module rr_arbiter
  import latch_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] gnt,
  output logic [IdxW-1:0]  idx
);

  logic [N_REQ-1:0] eligible;
  logic [IdxW-1:0]  cand;
  logic             found;

  assign eligible = req & ~mask;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IdxW'((32'(ptr) + i) % N_REQ);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/latch_share_arbiter.sv
// Sequences writes from N_REQ requesters into one shared level-enabled latch.
// Each transaction: WRITE (enable pulse) -> HOLD_CYCLES settle cycles -> ACK (readback + strobe).
// Ports:
//   i_clk : clock, all state on posedge
//   i_rst : synchronous active-high reset; aborts any transaction without an ack
//   bus   : master side of latch_share_arbiter_if (requests, grants, latch enable/data/readback)
// Optional build macro LATCH_SHARE_ARBITER_READBACK_CHECK_EN: compares readback against the
// written data when entering ACK and raises a sticky o_err on mismatch; otherwise o_err is 0.
module latch_share_arbiter
  import latch_share_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = 1,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  latch_share_arbiter_if.master bus
);

  localparam int unsigned IdxW = clog2_min1(N_REQ);
  localparam int unsigned CntW = clog2_min1(HOLD_CYCLES);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]     d_q, d_d;
  logic [W-1:0]     q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [IdxW-1:0]  ptr_next;
  logic [IdxW-1:0]  arb_ptr;
  logic [IdxW-1:0]  arb_idx;
  logic [N_REQ-1:0] arb_mask;
  logic [N_REQ-1:0] arb_gnt;
  logic             enter_ack;

  // Pointer after the current winner, wrapping at N_REQ-1.
  assign ptr_next = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);

  // In ACK the next winner is chosen from the advanced pointer with the current winner masked,
  // so a lone requester cannot take two back-to-back slots.
  always_comb begin
    arb_ptr  = ptr_q;
    arb_mask = '0;
    if (state_q == StAck) begin
      arb_ptr  = ptr_next;
      arb_mask = gnt_q;
    end
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_rr_arbiter (
    .req  (bus.i_req),
    .ptr  (arb_ptr),
    .mask (arb_mask),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    d_d       = d_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          d_d     = bus.i_data[arb_idx*W +: W];
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (HOLD_CYCLES > 0) begin
          cnt_d   = CntW'(HOLD_CYCLES - 1);
          state_d = StHold;
        end else begin
          enter_ack = 1'b1;
          state_d   = StAck;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          enter_ack = 1'b1;
          state_d   = StAck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAck: begin
        ptr_d = ptr_next;
        if (|arb_gnt) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          d_d     = bus.i_data[arb_idx*W +: W];
          state_d = StWrite;
        end else begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Readback is captured on the edge that enters ACK, after the settle window.
    if (enter_ack) begin
      q_d = bus.i_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      d_q     <= d_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_gnt  = gnt_q;
  assign bus.o_ack  = (state_q == StAck) ? gnt_q : '0;
  assign bus.o_en   = (state_q == StWrite);
  assign bus.o_d    = d_q;
  assign bus.o_q    = q_q;
  assign bus.o_busy = (state_q != StIdle);

`ifdef LATCH_SHARE_ARBITER_READBACK_CHECK_EN
  logic err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (enter_ack && (bus.i_q != d_q)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_share_arbiter.sv
// Bench for latch_share_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-schedule model (write cycle, ack cycle, winner) kept in the bench.
// A second instance with HOLD_CYCLES=0 serves a single held request throughout.
module tb_latch_share_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned W    = 4;
  localparam int          Hold = 2;
  localparam int          None = -100;
  localparam int          Never = 1 << 30;
`ifdef LATCH_SHARE_ARBITER_READBACK_CHECK_EN
  localparam bit ReadbackCheck = 1'b1;
`else
  localparam bit ReadbackCheck = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rst0;
  logic         force_q0;
  logic [W-1:0] lat_q;
  logic [W-1:0] lat0_q;

  always #5 clk = ~clk;

  latch_share_arbiter_if #(.N_REQ(NReq), .W(W)) bus ();
  latch_share_arbiter_if #(.N_REQ(NReq), .W(W)) bus0 ();

  latch_share_arbiter #(.N_REQ(NReq), .W(W), .HOLD_CYCLES(Hold)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  latch_share_arbiter #(.N_REQ(NReq), .W(W), .HOLD_CYCLES(0)) dut0 (
    .i_clk (clk),
    .i_rst (rst0),
    .bus   (bus0)
  );

  // The shared latches themselves; force_q0 corrupts the main readback path.
  always_latch if (bus.o_en) lat_q <= bus.o_d;
  always_latch if (bus0.o_en) lat0_q <= bus0.o_d;
  assign bus.i_q  = force_q0 ? '0 : lat_q;
  assign bus0.i_q = lat0_q;

  // Stimulus state
  logic [NReq-1:0] req;
  logic [W-1:0]    data [NReq];

  // Reference model: schedule of the current transaction
  int           cyc;
  int           m_ptr;
  int           m_w;
  int           m_write;
  int           m_ack;
  int           err_from;
  int           e0;
  logic [W-1:0] m_d;
  logic [W-1:0] m_qexp;

  int checks;
  int errors;

  function automatic logic [NReq-1:0] onehot(input int r);
    logic [NReq-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Decide what the edge ending the current cycle does.
  task automatic plan();
    logic [NReq-1:0] mask;
    int              r;
    bit              found;
    if (rst) begin
      m_ptr    = 0;
      m_write  = None;
      m_ack    = None;
      err_from = Never;
      return;
    end
    if (cyc >= m_write && cyc < m_ack) return;
    mask = '0;
    if (cyc == m_ack) begin
      m_ptr      = (m_w + 1) % NReq;
      mask[m_w]  = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      r = (m_ptr + i) % NReq;
      if (!found && req[r] && !mask[r]) begin
        found = 1'b1;
        m_w   = r;
      end
    end
    if (found) begin
      m_write = cyc + 1;
      m_ack   = cyc + 2 + Hold;
      m_d     = data[m_w];
      m_qexp  = force_q0 ? '0 : m_d;
      if (ReadbackCheck && force_q0 && m_d != '0 && err_from == Never) err_from = m_ack;
    end
  endtask

  task automatic check_cycle();
    logic            busy;
    logic [NReq-1:0] oh;
    int              p;
    busy = (cyc >= m_write) && (cyc <= m_ack);
    oh   = onehot(m_w);
    chk("busy", 32'(bus.o_busy), 32'(busy));
    chk("gnt", 32'(bus.o_gnt), busy ? 32'(oh) : 32'd0);
    chk("en", 32'(bus.o_en), 32'(cyc == m_write));
    chk("ack", 32'(bus.o_ack), (cyc == m_ack) ? 32'(oh) : 32'd0);
    if (busy) chk("d", 32'(bus.o_d), 32'(m_d));
    if (cyc == m_ack) chk("q", 32'(bus.o_q), 32'(m_qexp));
    chk("err", 32'(bus.o_err), 32'(cyc >= err_from));
    if (cyc >= e0) begin
      p = (cyc - e0) % 3;
      chk("h0_en", 32'(bus0.o_en), 32'(p == 1));
      chk("h0_ack", 32'(bus0.o_ack), (p == 2) ? 32'd1 : 32'd0);
      chk("h0_busy", 32'(bus0.o_busy), 32'(p != 0));
      if (p == 2) chk("h0_q", 32'(bus0.o_q), 32'd1);
    end
  endtask

  task automatic step(input bit rnd);
    if (rnd) begin
      for (int r = 0; r < NReq; r++) begin
        if (!req[r] && $urandom_range(0, 2) == 0) begin
          req[r]  = 1'b1;
          data[r] = W'($urandom);
        end
      end
    end
    bus.i_req = req;
    for (int r = 0; r < NReq; r++) bus.i_data[r*W +: W] = data[r];
    plan();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
    // Requester releases its request once it has seen its ack.
    if (cyc == m_ack) req[m_w] = 1'b0;
  endtask

  initial begin
    int ack_cyc[$];
    int ack_idx[$];
    int busy_drops;

    checks   = 0;
    errors   = 0;
    cyc      = 0;
    m_ptr    = 0;
    m_w      = 0;
    m_write  = None;
    m_ack    = None;
    err_from = Never;
    e0       = Never;
    m_d      = '0;
    m_qexp   = '0;
    force_q0 = 1'b0;
    rst      = 1'b1;
    rst0     = 1'b1;
    req      = '0;
    for (int r = 0; r < NReq; r++) data[r] = '0;
    bus.i_req   = '0;
    bus.i_data  = '0;
    bus0.i_req  = '0;
    bus0.i_data = '0;
    @(negedge clk);

    step(1'b0);
    step(1'b0);

    // Reset state
    rst  = 1'b0;
    rst0 = 1'b0;
    chk("rst_d", 32'(bus.o_d), 32'd0);
    chk("rst_q", 32'(bus.o_q), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst0_busy", 32'(bus0.o_busy), 32'd0);

    // HOLD_CYCLES=0 instance: requester 0 held from here on
    bus0.i_req  = 4'b0001;
    bus0.i_data = 16'h0001;
    e0          = cyc;

    // All four requesting continuously from pointer 0
    busy_drops = 0;
    for (int r = 0; r < NReq; r++) data[r] = W'(r + 1);
    for (int n = 0; n < 22; n++) begin
      req = '1;
      step(1'b0);
      if (bus.o_ack != '0) begin
        ack_cyc.push_back(cyc);
        for (int r = 0; r < NReq; r++) if (bus.o_ack[r]) ack_idx.push_back(r);
      end
      if (!bus.o_busy) busy_drops++;
    end
    chk("rot_acks", 32'(ack_cyc.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < ack_idx.size(); i++) chk("rot_order", 32'(ack_idx[i]), 32'(i % 4));
    for (int i = 1; i < 5 && i < ack_cyc.size(); i++)
      chk("rot_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
    chk("rot_busy_drops", 32'(busy_drops), 32'd0);
    req = '0;
    for (int n = 0; n < 6; n++) step(1'b0);

    // Single request 0100: cycle numbering relative to the sampling edge
    req     = 4'b0100;
    data[2] = 4'h1;
    step(1'b0);
    chk("single_gnt_c1", 32'(bus.o_gnt), 32'h4);
    chk("single_en_c1", 32'(bus.o_en), 32'd1);
    step(1'b0);
    chk("single_en_c2", 32'(bus.o_en), 32'd0);
    step(1'b0);
    chk("single_en_c3", 32'(bus.o_en), 32'd0);
    step(1'b0);
    chk("single_ack_c4", 32'(bus.o_ack), 32'h4);
    chk("single_q_c4", 32'(bus.o_q), 32'h1);
    step(1'b0);
    chk("single_busy_c5", 32'(bus.o_busy), 32'd0);

    // Reset during HOLD (pointer is 3 beforehand)
    req     = 4'b0100;
    data[2] = 4'h5;
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    req = '0;
    step(1'b0);
    chk("rsthold_busy", 32'(bus.o_busy), 32'd0);
    chk("rsthold_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rsthold_en", 32'(bus.o_en), 32'd0);
    chk("rsthold_ack", 32'(bus.o_ack), 32'd0);
    chk("rsthold_d", 32'(bus.o_d), 32'd0);
    chk("rsthold_q", 32'(bus.o_q), 32'd0);
    rst     = 1'b0;
    req     = 4'b1010;
    data[1] = 4'h9;
    data[3] = 4'h3;
    step(1'b0);
    chk("rsthold_ptr0_gnt", 32'(bus.o_gnt), 32'h2);
    for (int n = 0; n < 10; n++) step(1'b0);

    // Requester 1 drops its request during HOLD (pointer is 0 beforehand)
    req     = 4'b0010;
    data[1] = 4'hA;
    step(1'b0);
    step(1'b0);
    req[1] = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("drop_ack", 32'(bus.o_ack), 32'h2);
    req     = 4'b0101;
    data[0] = 4'h6;
    data[2] = 4'hC;
    step(1'b0);
    chk("drop_next_gnt", 32'(bus.o_gnt), 32'h4);
    for (int n = 0; n < 10; n++) step(1'b0);

    // Corrupted readback: i_q forced to 0 while o_d is 1
    force_q0 = 1'b1;
    req      = 4'b0001;
    data[0]  = 4'h1;
    for (int n = 0; n < 4; n++) step(1'b0);
    chk("err_at_ack", 32'(bus.o_err), 32'(ReadbackCheck));
    force_q0 = 1'b0;
    for (int n = 0; n < 3; n++) step(1'b0);
    chk("err_sticky", 32'(bus.o_err), 32'(ReadbackCheck));

    // Random traffic
    for (int n = 0; n < 400; n++) step(1'b1);
    req = '0;
    for (int n = 0; n < 12; n++) step(1'b0);

    // Reset clears the sticky flag
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    chk("err_cleared", 32'(bus.o_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
